// File: rtl/select_encoder_if.sv
// rtl/select_encoder_if.sv - button/code bundle between front panel and select encoder
//
// Purpose: groups the raw keypad lines and the encoder results into one port.
// Signals:
//   btn        2**N  raw asynchronous button lines, 1 = pressed
//   code       N     registered index of the last accepted button
//   valid      1     one-cycle pulse, code updated this cycle
//   multi_err  1     one-cycle pulse, multi-button press rejected
//   busy       1     encoder is debouncing or waiting for release
// Modports:
//   master  encoder side (consumes btn, drives results)
//   slave   panel/consumer side (drives btn, observes results)
interface select_encoder_if #(
  parameter int N = 2
);
  logic [2**N-1:0] btn;
  logic [N-1:0]    code;
  logic            valid;
  logic            multi_err;
  logic            busy;

  modport master (input btn, output code, output valid, output multi_err, output busy);
  modport slave  (output btn, input code, input valid, input multi_err, input busy);
endinterface

// File: rtl/select_encoder.sv
// rtl/select_encoder.sv - debounced one-hot keypad to binary index encoder
//
// Purpose: synchronises and debounces 2**N button lines, emits the index of a
//   single pressed button with a one-cycle valid pulse once per press, and
//   rejects multi-button presses with a one-cycle multi_err pulse.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    select_encoder_if.master (btn in; code/valid/multi_err/busy out)
module select_encoder #(
  parameter int N               = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  select_encoder_if.master    bus
);

  localparam int W  = 2**N;
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  logic [W-1:0]  s1, btn_s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  cap, cap_n;
  logic [N-1:0]  code_q, code_n;
  logic          valid_q, valid_n;
  logic          err_q, err_n;
  logic          busy_q;

  logic          cap_one_hot;
  logic [N-1:0]  cap_index;

  // cap & (cap-1) clears the lowest set bit; zero result means at most one bit.
  assign cap_one_hot = (cap != '0) && ((cap & (cap - W'(1))) == '0);

  always_comb begin
    cap_index = '0;
    for (int i = 0; i < W; i++) begin
      if (cap[i]) cap_index = N'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '0;
      btn_s   <= '0;
      state   <= IDLE;
      cnt     <= '0;
      cap     <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1      <= bus.btn;
      btn_s   <= s1;
      state   <= state_n;
      cnt     <= cnt_n;
      cap     <= cap_n;
      code_q  <= code_n;
      valid_q <= valid_n;
      err_q   <= err_n;
      // Registered alongside state so busy tracks the state register exactly.
      busy_q  <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap_n   = cap;
    code_n  = code_q;
    valid_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s != '0) begin
          cap_n   = btn_s;
          cnt_n   = CW'(1);
          state_n = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (btn_s == '0) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (btn_s != cap) begin
          // Pattern changed mid-debounce: restart on the new pattern.
          cap_n = btn_s;
          cnt_n = CW'(1);
        end else if (cnt != CNT_LAST) begin
          cnt_n = cnt + CW'(1);
        end else begin
          // Release counting starts from zero on entry to WAIT_RELEASE.
          cnt_n   = '0;
          state_n = WAIT_RELEASE;
          if (cap_one_hot) begin
            code_n  = cap_index;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      WAIT_RELEASE: begin
        if (btn_s != '0) begin
          cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.code      = code_q;
  assign bus.valid     = valid_q;
  assign bus.multi_err = err_q;
  assign bus.busy      = busy_q;

endmodule
